dac_serial_tx: RTL and testbench
================================

DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

Interface
REQ-001 clk  input  1  system clock, 12.5 MHz; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clock clk.
REQ-003 start  input  1  request one conversion frame; level-sampled.
REQ-004 data_a  input  12  channel A code, unsigned.
REQ-005 data_b  input  12  channel B code, unsigned.
REQ-006 mode  input  2  DAC power-down/mode bits, shared by both channels.
REQ-007 sync  output  1  active-low frame select to both DACs.
REQ-008 sclk  output  1  serial clock to DACs, idles high, clk/2 while shifting.
REQ-009 dina  output  1  serial data, channel A, MSB first.
REQ-010 dinb  output  1  serial data, channel B, MSB first.
REQ-011 busy  output  1  high from accepting a frame until ready for the next one.
REQ-012 done  output  1  one-cycle pulse at frame end.

Function
REQ-013 States SHALL be IDLE, SHIFT and GAP, one-hot or encoded; no other reachable state.
REQ-014 Frame word SHALL be {2'b00, mode, data} = 16 bits, for A and B independently.
REQ-015 IDLE: sync=1, sclk=1, busy=0, done=0; dina/dinb hold their last value.
REQ-016 IDLE with start=1 at edge E0: capture both frame words, mode and data; SHALL enter SHIFT; sync=0, sclk=1, dina/dinb=bit 15, bit counter=15, phase=0.
REQ-017 SHIFT, phase 0: sclk<=0, phase<=1; data unchanged. The DAC samples on this falling edge.
REQ-018 SHIFT, phase 1, counter>0: sclk<=1, phase<=0, counter decrements, dina/dinb<=next lower bit.
REQ-019 SHIFT, phase 1, counter=0: sclk<=1, sync<=1, done<=1, enter GAP.
REQ-020 Each bit SHALL be held 2 clk cycles. sync SHALL be low for exactly 32 cycles (E0 to E0+32). There SHALL be exactly 16 sclk falling edges per frame.
REQ-021 GAP: lasts 1 cycle; done<=0; busy stays 1; enter IDLE at E0+33.
REQ-022 Earliest next acceptance SHALL be E0+34, so sync is high for at least 2 cycles between frames. Frame period with start held high = 34 cycles.
REQ-023 busy SHALL be 1 from E0 through the cycle ending at E0+33 inclusive.
REQ-024 start while busy=1 SHALL be ignored and not queued.
REQ-025 data_a, data_b and mode changes after E0 SHALL NOT affect the frame in flight.
REQ-026 sclk SHALL never toggle while sync=1. sync SHALL change only while sclk=1.
REQ-027 No combinational path from any input to any output; all outputs registered.

Reset
REQ-028 On reset assertion, immediately and asynchronously: state=IDLE, sync=1, sclk=1, dina=0, dinb=0, busy=0, done=0, counter=0, phase=0, frame registers=0.
REQ-029 Reset mid-frame SHALL abort the frame without a done pulse. The first start after release SHALL produce a complete 16-bit frame.
REQ-030 start high during reset SHALL NOT be accepted before the first rising edge after release.

Verification
REQ-031 Assert reset, then release -> sync=1, sclk=1, dina=dinb=0, busy=0, done=0; all stay that way with start=0 for 100 cycles.
REQ-032 start 1-cycle pulse, data_a=12'hA5C, data_b=12'h3F0, mode=00 -> on 16 sclk falling edges, dina shifts 0x0A5C and dinb shifts 0x03F0; sync low for exactly 32 cycles; done=1 exactly at E0+32.
REQ-033 start held high, data_a incrementing each frame -> back-to-back frames, 34-cycle period, sync high exactly 2 cycles between frames, one done per frame.
REQ-034 start re-pulsed and data_a changed to 12'h000 at E0+10 -> current frame still 0x0A5C; no extra frame; busy stays high.
REQ-035 reset pulse at E0+17 -> sync=1 and sclk=1 immediately, no done; new start with mode=11, data_a=12'hFFF -> frame 0x3FFF on dina.
REQ-036 Monitor assertions for all tests: sclk constant while sync=1; dina/dinb stable across every sclk falling edge; busy=0 only in IDLE.

Source files
------------

// File: rtl/dac_serial_tx.sv
// dac_serial_tx
// Serialises one 16-bit frame per channel ({2'b00, mode, data}) to a pair of
// SPI-style DACs that share sync and sclk. Each bit is held for two clk
// cycles. The DAC samples data on the falling sclk edge. A frame occupies 34
// cycles from acceptance to the next possible acceptance.
//
// Ports
//   clk     in   system clock, all state on the rising edge
//   reset   in   asynchronous, active-high reset
//   start   in   level-sampled request for one frame (ignored while busy)
//   data_a  in   channel A code, unsigned
//   data_b  in   channel B code, unsigned
//   mode    in   DAC power-down/mode bits, shared by both channels
//   sync    out  active-low frame select to both DACs
//   sclk    out  serial clock, idles high, clk/2 while shifting
//   dina    out  channel A serial data, MSB first
//   dinb    out  channel B serial data, MSB first
//   busy    out  high from frame acceptance until ready for the next frame
//   done    out  one-cycle pulse at frame end
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.

module dac_serial_tx #(
    localparam int unsigned DATA_W  = 12,
    localparam int unsigned MODE_W  = 2,
    localparam int unsigned PAD_W   = 2,
    localparam int unsigned FRAME_W = PAD_W + MODE_W + DATA_W,
    localparam int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [MODE_W-1:0] mode,
    output logic              sync,
    output logic              sclk,
    output logic              dina,
    output logic              dinb,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               sync_q,  sync_d;
    logic               sclk_q,  sclk_d;
    logic               dina_q,  dina_d;
    logic               dinb_q,  dinb_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [FRAME_W-1:0] sh_a_q,  sh_a_d;
    logic [FRAME_W-1:0] sh_b_q,  sh_b_d;

    logic [FRAME_W-1:0] word_a;
    logic [FRAME_W-1:0] word_b;
    logic               accept;
    logic               last_bit;

    // Frame words as presented to the DACs
    assign word_a = {PAD_W'(0), mode, data_a};
    assign word_b = {PAD_W'(0), mode, data_b};

    assign accept   = (state_q == ST_IDLE) && start;
    // Second half of bit 0: the frame ends on this edge
    assign last_bit = phase_q && (cnt_q == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        sync_d  = sync_q;
        sclk_d  = sclk_q;
        dina_d  = dina_q;
        dinb_d  = dinb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;

        case (state_q)
            ST_IDLE: begin
                sync_d = 1'b1;
                sclk_d = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    // Snapshot both words so later input changes cannot
                    // disturb the frame; the MSB goes out immediately.
                    sh_a_d  = word_a;
                    sh_b_d  = word_b;
                    dina_d  = word_a[FRAME_W-1];
                    dinb_d  = word_b[FRAME_W-1];
                    sync_d  = 1'b0;
                    cnt_d   = CNT_W'(FRAME_W - 1);
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (!phase_q) begin
                    // Falling sclk; data stays put while the DAC samples it
                    sclk_d  = 1'b0;
                    phase_d = 1'b1;
                end else begin
                    sclk_d  = 1'b1;
                    phase_d = 1'b0;
                    if (cnt_q != '0) begin
                        // Rising sclk; present the next lower bit
                        cnt_d  = cnt_q - CNT_W'(1);
                        sh_a_d = sh_a_q << 1;
                        sh_b_d = sh_b_q << 1;
                        dina_d = sh_a_q[FRAME_W-2];
                        dinb_d = sh_b_q[FRAME_W-2];
                    end else begin
                        // sclk is back high on this edge, so sync may rise
                        sync_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                // One-cycle pause so sync stays high for two cycles minimum
                busy_d = 1'b0;
            end

            default: begin
                sync_d = 1'b1;
                sclk_d = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            dina_q  <= 1'b0;
            dinb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            sclk_q  <= sclk_d;
            dina_q  <= dina_d;
            dinb_q  <= dinb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
        end
    end

    assign sync = sync_q;
    assign sclk = sclk_q;
    assign dina = dina_q;
    assign dinb = dinb_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx. A monitor samples the outputs 1 time unit
// after each rising edge, counts cycles, and records sclk falls, sync-low
// cycles, done pulses and the serial words seen at each falling sclk edge.
// The main sequence drives inputs and compares on falling clk edges.

module tb_dac_serial_tx;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] data_a;
    logic [11:0] data_b;
    logic [1:0]  mode;
    logic        sync;
    logic        sclk;
    logic        dina;
    logic        dinb;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    dac_serial_tx dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data_a (data_a),
        .data_b (data_b),
        .mode   (mode),
        .sync   (sync),
        .sclk   (sclk),
        .dina   (dina),
        .dinb   (dinb),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #40 clk = ~clk;

    // Monitor state
    int          cyc          = 0;
    int          falls_tot    = 0;
    int          done_tot     = 0;
    int          sync_low_tot = 0;
    int          done_cyc     = -1;
    int          hi_run       = 0;
    int          last_gap     = 0;
    int          viol         = 0;
    logic [15:0] cap_a        = '0;
    logic [15:0] cap_b        = '0;
    logic        sclk_p       = 1'b1;
    logic        dina_p       = 1'b0;
    logic        dinb_p       = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        // sclk must sit high whenever the frame is deselected
        if (sync === 1'b1 && sclk !== 1'b1) viol = viol + 1;
        // a deselected frame is the only legal state with busy low
        if (busy === 1'b0 && sync !== 1'b1) viol = viol + 1;
        if (sclk_p === 1'b1 && sclk === 1'b0) begin
            falls_tot = falls_tot + 1;
            cap_a = {cap_a[14:0], dina};
            cap_b = {cap_b[14:0], dinb};
            if (dina !== dina_p || dinb !== dinb_p) viol = viol + 1;
        end
        if (sync === 1'b0) sync_low_tot = sync_low_tot + 1;
        if (done === 1'b1) begin
            done_tot = done_tot + 1;
            done_cyc = cyc;
        end
        if (sync === 1'b1) begin
            hi_run = hi_run + 1;
        end else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
        sclk_p = sclk;
        dina_p = dina;
        dinb_p = dinb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the falling clk edge following rising edge number t
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called on a falling edge; returns with e0 = accepting edge, at its negedge
    task automatic start_pulse(input logic [11:0] a, input logic [11:0] b,
                               input logic [1:0] m, output int e0);
        data_a = a;
        data_b = b;
        mode   = m;
        start  = 1'b1;
        e0     = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int f0;
        int d0;
        int s0;
        int bad;

        reset  = 1'b0;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;
        mode   = '0;

        // Asynchronous reset, observed before any clock edge
        #5 reset = 1'b1;
        #1;
        check("rst_sync", 32'(sync), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_dina", 32'(dina), 32'd0);
        check("rst_dinb", 32'(dinb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // start held during reset must not be taken
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start_sync", 32'(sync), 32'd1);
        check("rst_start_busy", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;

        // Idle for 100 cycles
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({sync, sclk, dina, dinb, busy, done} !== 6'b110000) bad = bad + 1;
        end
        check("idle_100", 32'(bad), 32'd0);

        // Single frame
        f0 = falls_tot; d0 = done_tot; s0 = sync_low_tot;
        start_pulse(12'hA5C, 12'h3F0, 2'b00, e0);
        check("f1_sync_e0", 32'(sync), 32'd0);
        check("f1_sclk_e0", 32'(sclk), 32'd1);
        check("f1_busy_e0", 32'(busy), 32'd1);
        check("f1_dina_msb", 32'(dina), 32'd0);
        wait_until(e0 + 1);
        check("f1_sclk_fall", 32'(sclk), 32'd0);
        wait_until(e0 + 32);
        check("f1_done", 32'(done), 32'd1);
        check("f1_sync_end", 32'(sync), 32'd1);
        check("f1_busy_end", 32'(busy), 32'd1);
        wait_until(e0 + 33);
        check("f1_done_clr", 32'(done), 32'd0);
        check("f1_busy_clr", 32'(busy), 32'd0);
        wait_until(e0 + 36);
        check("f1_word_a", 32'(cap_a), 32'h0A5C);
        check("f1_word_b", 32'(cap_b), 32'h03F0);
        check("f1_falls", 32'(falls_tot - f0), 32'd16);
        check("f1_sync_low", 32'(sync_low_tot - s0), 32'd32);
        check("f1_done_cnt", 32'(done_tot - d0), 32'd1);
        check("f1_done_cyc", 32'(done_cyc), 32'(e0 + 32));

        // Back-to-back frames with start held high
        d0 = done_tot;
        data_a = 12'h100;
        data_b = 12'h000;
        mode   = 2'b00;
        start  = 1'b1;
        e0     = cyc + 1;
        @(negedge clk);
        data_a = 12'h101;
        wait_until(e0 + 33);
        check("b2b_busy_gap", 32'(busy), 32'd0);
        wait_until(e0 + 34);
        check("b2b_busy_next", 32'(busy), 32'd1);
        check("b2b_sync_next", 32'(sync), 32'd0);
        check("b2b_done1_cyc", 32'(done_cyc), 32'(e0 + 32));
        check("b2b_word1", 32'(cap_a), 32'h0100);
        data_a = 12'h102;
        wait_until(e0 + 35);
        check("b2b_sync_gap", 32'(last_gap), 32'd2);
        wait_until(e0 + 66);
        check("b2b_done2_cyc", 32'(done_cyc), 32'(e0 + 66));
        check("b2b_word2", 32'(cap_a), 32'h0101);
        wait_until(e0 + 68);
        start = 1'b0;
        check("b2b_sync_f3", 32'(sync), 32'd0);
        wait_until(e0 + 104);
        check("b2b_word3", 32'(cap_a), 32'h0102);
        check("b2b_done_cnt", 32'(done_tot - d0), 32'd3);
        check("b2b_busy_idle", 32'(busy), 32'd0);

        // start re-pulsed and data changed mid-frame
        f0 = falls_tot; d0 = done_tot;
        start_pulse(12'hA5C, 12'h3F0, 2'b00, e0);
        wait_until(e0 + 10);
        start  = 1'b1;
        data_a = 12'h000;
        @(negedge clk);
        start  = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_until(e0 + 32);
        check("ign_done", 32'(done), 32'd1);
        wait_until(e0 + 80);
        check("ign_word", 32'(cap_a), 32'h0A5C);
        check("ign_done_cnt", 32'(done_tot - d0), 32'd1);
        check("ign_falls", 32'(falls_tot - f0), 32'd16);
        check("ign_busy_idle", 32'(busy), 32'd0);
        check("ign_sync_idle", 32'(sync), 32'd1);

        // Reset mid-frame, then a fresh frame
        d0 = done_tot;
        start_pulse(12'hA5C, 12'h3F0, 2'b00, e0);
        wait_until(e0 + 17);
        check("abort_sclk_pre", 32'(sclk), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_sync", 32'(sync), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dina", 32'(dina), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_tot - d0), 32'd0);

        f0 = falls_tot; d0 = done_tot;
        start_pulse(12'hFFF, 12'h123, 2'b11, e0);
        check("m3_dina_b15", 32'(dina), 32'd0);
        wait_until(e0 + 4);
        check("m3_dina_b13", 32'(dina), 32'd1);
        wait_until(e0 + 36);
        check("m3_word_a", 32'(cap_a), 32'h3FFF);
        check("m3_word_b", 32'(cap_b), 32'h3123);
        check("m3_falls", 32'(falls_tot - f0), 32'd16);
        check("m3_done_cnt", 32'(done_tot - d0), 32'd1);
        check("m3_dina_hold", 32'(dina), 32'd1);

        check("monitor_viol", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
